// File: rtl/fht_pkg.sv
// Shared types, latency derivation and address/coefficient helpers for the
// FHT address sequencer and the butterfly wrapper.
package fht_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } fht_state_t;

    function automatic int fht_lat(input int rd_lat, input int but_lat);
        return rd_lat + but_lat;
    endfunction

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int stage_w(input int n_log2);
        return clog2_min1(n_log2);
    endfunction

    function automatic int coef_w(input int n_log2);
        return n_log2 - 1;
    endfunction

    // Butterfly j of stage s touches a group of 2h points starting at g.
    function automatic int unsigned fht_addr0(input int unsigned s, input int unsigned j);
        int unsigned h, k, g;
        h = 32'd1 << s;
        k = j & (h - 32'd1);
        g = (j >> s) << (s + 32'd1);
        return g + k;
    endfunction

    function automatic int unsigned fht_addr1(input int unsigned s, input int unsigned j);
        int unsigned h, k, g;
        h = 32'd1 << s;
        k = j & (h - 32'd1);
        g = (j >> s) << (s + 32'd1);
        return g + h + k;
    endfunction

    // The Hartley cross term reads the mirrored partner; k=0 pairs with itself.
    function automatic int unsigned fht_addr2(input int unsigned s, input int unsigned j);
        int unsigned h, k, g;
        h = 32'd1 << s;
        k = j & (h - 32'd1);
        g = (j >> s) << (s + 32'd1);
        return (k == 32'd0) ? (g + h) : (g + 2 * h - k);
    endfunction

    function automatic int unsigned fht_coef(input int unsigned n_log2, input int unsigned s,
                                             input int unsigned j);
        int unsigned h, k;
        h = 32'd1 << s;
        k = j & (h - 32'd1);
        return k << (n_log2 - 32'd1 - s);
    endfunction

endpackage

// File: rtl/fht_delay_line.sv
// Fixed-depth shift register with asynchronous active-low clear; carries the
// write strobe, bank and addresses from the read port to the write port.
module fht_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_pipe [DEPTH];

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
        end else begin
            r_pipe[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign o_data = r_pipe[DEPTH-1];

endmodule

// File: rtl/fht_addr_gen.sv
// Read/write address sequencer for a radix-2 in-place FHT over two ping-pong
// banks: one butterfly per cycle, stages separated by a pipeline flush.
module fht_addr_gen
    import fht_pkg::*;
#(
    parameter int N_LOG2  = 8,
    parameter int RD_LAT  = 1,
    parameter int BUT_LAT = 2
) (
    input  logic                                iCLK,
    input  logic                                iRESET,
    input  logic                                iSTART,
    output logic                                oBUSY,
    output logic                                oDONE,
    output logic [stage_w(N_LOG2)-1:0]          oSTAGE,
    output logic                                oRD_EN,
    output logic                                oRD_BANK,
    output logic [N_LOG2-1:0]                   oRD_ADDR_0,
    output logic [N_LOG2-1:0]                   oRD_ADDR_1,
    output logic [N_LOG2-1:0]                   oRD_ADDR_2,
    output logic [coef_w(N_LOG2)-1:0]           oCOEF_ADDR,
    output logic                                oWR_EN,
    output logic                                oWR_BANK,
    output logic [N_LOG2-1:0]                   oWR_ADDR_0,
    output logic [N_LOG2-1:0]                   oWR_ADDR_1
);

    localparam int AW  = N_LOG2;
    localparam int CW  = coef_w(N_LOG2);
    localparam int SW  = stage_w(N_LOG2);
    localparam int JW  = N_LOG2 - 1;
    localparam int LAT = fht_lat(RD_LAT, BUT_LAT);
    localparam int FW  = clog2_min1(LAT);
    localparam int DW  = 2 + 2 * AW;

    localparam logic [JW-1:0] J_LAST = '1;
    localparam logic [SW-1:0] S_LAST = SW'(N_LOG2 - 1);
    localparam logic [FW-1:0] F_LAST = FW'(LAT - 1);

    fht_state_t      r_state;
    logic [SW-1:0]   r_stage;
    logic [JW-1:0]   r_j;
    logic [FW-1:0]   r_flush;
    logic            r_busy;
    logic            r_done;
    logic            r_rd_en;
    logic            r_rd_bank;
    logic [AW-1:0]   r_rd_addr0;
    logic [AW-1:0]   r_rd_addr1;
    logic [AW-1:0]   r_rd_addr2;
    logic [CW-1:0]   r_coef;

    logic            w_issue;
    logic [SW-1:0]   w_issue_s;
    logic [JW-1:0]   w_issue_j;
    logic [DW-1:0]   w_wr_in;
    logic [DW-1:0]   w_wr_out;

    // Decide whether a butterfly is issued on the next edge, and which (s, j) it is.
    always_comb begin
        w_issue   = 1'b0;
        w_issue_s = '0;
        w_issue_j = '0;
        case (r_state)
            IDLE:  w_issue = iSTART;
            RUN: begin
                w_issue   = (r_j != J_LAST);
                w_issue_s = r_stage;
                w_issue_j = r_j + JW'(1);
            end
            FLUSH: begin
                w_issue   = (r_flush == F_LAST) && (r_stage != S_LAST);
                w_issue_s = r_stage + SW'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            r_state   <= IDLE;
            r_stage   <= '0;
            r_j       <= '0;
            r_flush   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_rd_en   <= 1'b0;
            r_rd_bank <= 1'b0;
        end else begin
            r_rd_en <= w_issue;
            r_done  <= 1'b0;
            if (w_issue) begin
                r_stage   <= w_issue_s;
                r_j       <= w_issue_j;
                r_rd_bank <= w_issue_s[0];
            end
            case (r_state)
                IDLE: begin
                    if (iSTART) begin
                        r_state <= RUN;
                        r_busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (r_j == J_LAST) begin
                        r_state <= FLUSH;
                        r_flush <= '0;
                    end
                end
                FLUSH: begin
                    if (r_flush == F_LAST) begin
                        if (r_stage == S_LAST) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= RUN;
                        end
                    end else begin
                        r_flush <= r_flush + FW'(1);
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            r_rd_addr0 <= '0;
            r_rd_addr1 <= '0;
            r_rd_addr2 <= '0;
            r_coef     <= '0;
        end else if (w_issue) begin
            r_rd_addr0 <= AW'(fht_addr0(32'(w_issue_s), 32'(w_issue_j)));
            r_rd_addr1 <= AW'(fht_addr1(32'(w_issue_s), 32'(w_issue_j)));
            r_rd_addr2 <= AW'(fht_addr2(32'(w_issue_s), 32'(w_issue_j)));
            r_coef     <= CW'(fht_coef(32'(N_LOG2), 32'(w_issue_s), 32'(w_issue_j)));
        end
    end

    // Bank is gated by the strobe so the write port stays quiet while idle.
    assign w_wr_in = {r_rd_en, r_rd_en & ~r_rd_bank, r_rd_addr0, r_rd_addr1};

    fht_delay_line #(
        .WIDTH (DW),
        .DEPTH (LAT)
    ) u_wr_delay (
        .iCLK   (iCLK),
        .iRESET (iRESET),
        .i_data (w_wr_in),
        .o_data (w_wr_out)
    );

    assign oBUSY      = r_busy;
    assign oDONE      = r_done;
    assign oSTAGE     = r_stage;
    assign oRD_EN     = r_rd_en;
    assign oRD_BANK   = r_rd_bank;
    assign oRD_ADDR_0 = r_rd_addr0;
    assign oRD_ADDR_1 = r_rd_addr1;
    assign oRD_ADDR_2 = r_rd_addr2;
    assign oCOEF_ADDR = r_coef;
    assign oWR_EN     = w_wr_out[DW-1];
    assign oWR_BANK   = w_wr_out[DW-2];
    assign oWR_ADDR_0 = w_wr_out[2*AW-1:AW];
    assign oWR_ADDR_1 = w_wr_out[AW-1:0];

endmodule

// File: tb/tb_fht_addr_gen.sv
// Scoreboard bench for fht_addr_gen at N_LOG2=3: expected read and write
// tuples are queued when a transform is started and popped by a monitor.
module tb_fht_addr_gen;

    localparam int NL = 3;

    logic       iCLK = 1'b0;
    logic       iRESET = 1'b0;
    logic       iSTART = 1'b0;
    logic       oBUSY, oDONE, oRD_EN, oRD_BANK, oWR_EN, oWR_BANK;
    logic [1:0] oSTAGE;
    logic [2:0] oRD_ADDR_0, oRD_ADDR_1, oRD_ADDR_2, oWR_ADDR_0, oWR_ADDR_1;
    logic [1:0] oCOEF_ADDR;

    fht_addr_gen #(
        .N_LOG2  (NL),
        .RD_LAT  (1),
        .BUT_LAT (2)
    ) dut (
        .iCLK       (iCLK),
        .iRESET     (iRESET),
        .iSTART     (iSTART),
        .oBUSY      (oBUSY),
        .oDONE      (oDONE),
        .oSTAGE     (oSTAGE),
        .oRD_EN     (oRD_EN),
        .oRD_BANK   (oRD_BANK),
        .oRD_ADDR_0 (oRD_ADDR_0),
        .oRD_ADDR_1 (oRD_ADDR_1),
        .oRD_ADDR_2 (oRD_ADDR_2),
        .oCOEF_ADDR (oCOEF_ADDR),
        .oWR_EN     (oWR_EN),
        .oWR_BANK   (oWR_BANK),
        .oWR_ADDR_0 (oWR_ADDR_0),
        .oWR_ADDR_1 (oWR_ADDR_1)
    );

    always #5 iCLK = ~iCLK;

    // Hand-derived read schedule, stage-major, four butterflies per stage.
    int tA0 [12] = '{0, 2, 4, 6,  0, 1, 4, 5,  0, 1, 2, 3};
    int tA1 [12] = '{1, 3, 5, 7,  2, 3, 6, 7,  4, 5, 6, 7};
    int tA2 [12] = '{1, 3, 5, 7,  2, 3, 6, 7,  4, 7, 6, 5};
    int tCf [12] = '{0, 0, 0, 0,  0, 2, 0, 2,  0, 1, 2, 3};

    logic [13:0] rdQ [$];
    logic [6:0]  wrQ [$];
    int          wrCycQ [$];

    int nChecks = 0;
    int nErrors = 0;
    int cycleNum = 0;
    int busyCount = 0;
    int wrCount = 0;
    int rdCount = 0;
    int doneCount = 0;
    int firstRdCycle = -1;
    int startCycle = 0;
    bit prevBusy = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nErrors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] allOut();
        return {7'd0, oBUSY, oDONE, oSTAGE, oRD_EN, oRD_BANK, oRD_ADDR_0, oRD_ADDR_1,
                oRD_ADDR_2, oCOEF_ADDR, oWR_EN, oWR_BANK, oWR_ADDR_0, oWR_ADDR_1};
    endfunction

    always @(posedge iCLK) cycleNum++;

    always @(negedge iCLK) begin
        logic [13:0] expRd;
        logic [6:0]  expWr;
        int          expCyc;
        if (iRESET) begin
            if (oBUSY) busyCount++;
            if (oDONE) begin
                doneCount++;
                checkOutput("done_after_busy_fall", {31'd0, prevBusy & ~oBUSY}, 32'd1);
            end
            if (oRD_EN) begin
                if (rdCount == 0) firstRdCycle = cycleNum;
                rdCount++;
                if (rdQ.size() == 0) begin
                    checkOutput("unexpected_read", {31'd0, oRD_EN}, 32'd0);
                end else begin
                    expRd = rdQ.pop_front();
                    checkOutput("read_tuple",
                                {18'd0, oSTAGE, oRD_BANK, oRD_ADDR_0, oRD_ADDR_1, oRD_ADDR_2, oCOEF_ADDR},
                                {18'd0, expRd});
                    wrCycQ.push_back(cycleNum + 3);
                end
            end
            if (oWR_EN) begin
                wrCount++;
                if (wrQ.size() == 0) begin
                    checkOutput("unexpected_write", {31'd0, oWR_EN}, 32'd0);
                end else begin
                    expWr  = wrQ.pop_front();
                    expCyc = (wrCycQ.size() != 0) ? wrCycQ.pop_front() : -1;
                    checkOutput("write_tuple", {25'd0, oWR_BANK, oWR_ADDR_0, oWR_ADDR_1}, {25'd0, expWr});
                    checkOutput("write_cycle", cycleNum, expCyc);
                end
            end
        end
        prevBusy = iRESET & oBUSY;
    end

    task automatic resetCounters();
        busyCount    = 0;
        wrCount      = 0;
        rdCount      = 0;
        doneCount    = 0;
        firstRdCycle = -1;
    endtask

    task automatic applyStimulus();
        logic [1:0] st;
        for (int i = 0; i < 12; i++) begin
            st = 2'(i / 4);
            rdQ.push_back({st, st[0], 3'(tA0[i]), 3'(tA1[i]), 3'(tA2[i]), 2'(tCf[i])});
            wrQ.push_back({~st[0], 3'(tA0[i]), 3'(tA1[i])});
        end
        @(posedge iCLK); #1 iSTART = 1'b1;
        @(posedge iCLK); #1 iSTART = 1'b0;
        startCycle = cycleNum;
    endtask

    task automatic waitDone(input int budget);
        int n = 0;
        while (doneCount == 0 && n < budget) begin
            @(posedge iCLK);
            n++;
        end
        if (doneCount == 0) begin
            nChecks++;
            nErrors++;
            $display("[TB] FAIL done_timeout: got no oDONE, expected one within %0d cycles", budget);
        end
    endtask

    task automatic waitStage1();
        int n = 0;
        do begin
            @(posedge iCLK); #1;
            n++;
        end while (!(oSTAGE == 2'd1 && oRD_EN) && n < 100);
        if (!(oSTAGE == 2'd1 && oRD_EN)) begin
            nChecks++;
            nErrors++;
            $display("[TB] FAIL stage1_timeout: got stage %0d, expected stage 1 reads", oSTAGE);
        end
    endtask

    task automatic checkRun(input string tag);
        repeat (4) @(posedge iCLK);
        #1;
        checkOutput({tag, "_busy_cycles"}, busyCount, 21);
        checkOutput({tag, "_write_count"}, wrCount, 12);
        checkOutput({tag, "_done_count"}, doneCount, 1);
        checkOutput({tag, "_first_read_cycle"}, firstRdCycle, startCycle);
        checkOutput({tag, "_queues_drained"}, rdQ.size() + wrQ.size(), 0);
    endtask

    initial begin
        repeat (2) @(posedge iCLK);
        #1 checkOutput("reset_outputs", allOut(), 32'd0);
        iRESET = 1'b1;

        $display("[TB] run 1: plain transform");
        resetCounters();
        applyStimulus();
        waitDone(200);
        checkRun("run1");

        $display("[TB] run 2: start pulse during stage 1");
        resetCounters();
        applyStimulus();
        waitStage1();
        iSTART = 1'b1;
        @(posedge iCLK); #1 iSTART = 1'b0;
        waitDone(200);
        checkRun("run2");

        $display("[TB] run 3: reset during stage 1");
        resetCounters();
        applyStimulus();
        waitStage1();
        @(posedge iCLK); #1 iRESET = 1'b0;
        #1 checkOutput("midrun_reset_outputs", allOut(), 32'd0);
        rdQ.delete();
        wrQ.delete();
        wrCycQ.delete();
        repeat (2) @(posedge iCLK);
        #1 iRESET = 1'b1;
        resetCounters();
        repeat (12) @(posedge iCLK);
        #1;
        checkOutput("post_reset_writes", wrCount, 0);
        checkOutput("post_reset_reads", rdCount, 0);

        $display("[TB] run 4: clean transform after reset");
        resetCounters();
        applyStimulus();
        waitDone(200);
        checkRun("run4");

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
